alu4_issuer: RTL and testbench
==============================

ALU4_ISSUER -- requirements
Module: alu4_issuer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  FIFO can accept; high iff FIFO not full.
REQ-006 cmd_op  in  3  ALU opcode, 000 add .. 111 equal.
REQ-007 cmd_a, cmd_b  in  4 each  operands.
REQ-008 alu_a, alu_b  out  4 each  registered operands to the 4-bit ALU.
REQ-009 alu_op  out  3  registered opcode to the ALU.
REQ-010 alu_result  in  4  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-011 alu_carry, alu_overflow, alu_zero  in  1 each  ALU flags.
REQ-012 rsp_valid  out  1  response held.
REQ-013 rsp_ready  in  1  consumer accepts.
REQ-014 rsp_result  out  4  captured result.
REQ-015 rsp_flags  out  3  captured {carry, overflow, zero}.
REQ-016 rsp_op  out  3  opcode that produced the response.
REQ-017 issued_cnt  out  8  completed-operation count, wraps 255->0.

Function
REQ-018 Command handshake: a push occurs on the rising edge where cmd_valid && cmd_ready; {op,a,b} is written at the FIFO tail.
REQ-019 FIFO is first-in first-out; write/read pointers are log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-020 Push and pop in the same cycle on a full FIFO: the push is refused, because cmd_ready is low.
REQ-021 Push and pop in the same cycle on a non-empty, non-full FIFO: both take effect and the occupancy is unchanged.
REQ-022 FSM states: IDLE, ISSUE, HOLD.
REQ-023 IDLE: when the FIFO is non-empty, pop the head, load it into alu_a/alu_b/alu_op, and go to ISSUE.
REQ-024 ISSUE (one cycle): capture alu_result into rsp_result, {alu_carry,alu_overflow,alu_zero} into rsp_flags, and alu_op into rsp_op; set rsp_valid; increment issued_cnt; go to HOLD.
REQ-025 HOLD: rsp_result, rsp_flags and rsp_op stay stable while rsp_valid && !rsp_ready.
REQ-026 HOLD on rsp_ready, FIFO non-empty: pop and load the next command into alu_*; clear rsp_valid; go to ISSUE.
REQ-027 HOLD on rsp_ready, FIFO empty: clear rsp_valid; go to IDLE.
REQ-028 Latency: a push into an empty FIFO with the FSM in IDLE gives rsp_valid high 3 cycles later (push edge, pop edge, capture edge).
REQ-029 Throughput: one response per 2 cycles while rsp_ready is held high.
REQ-030 alu_a/alu_b/alu_op change only on a pop; otherwise they hold their value.
REQ-031 The block does not interpret the opcode; the ALU supplies all arithmetic and flags.
REQ-032 A command is never dropped or duplicated; responses keep command order.
REQ-033 Illegal FSM encoding returns to IDLE on the next edge.

Reset
REQ-034 While rst_n is low, the following hold immediately (asynchronous): FSM=IDLE; FIFO pointers=0; cmd_ready=1; rsp_valid=0; rsp_result=0; rsp_flags=0; rsp_op=0; alu_a=0; alu_b=0; alu_op=0; issued_cnt=0.
REQ-035 Reset asserted mid-operation discards all queued and in-flight commands.
REQ-036 No push, pop or capture occurs on the first clk edge after rst_n deasserts if that edge coincides with the deassertion.

Verification
REQ-037 Single add: push op=000, a=7, b=1 with the ALU model attached -> 3 cycles later rsp_valid=1, rsp_result=8, rsp_flags=3'b010 (overflow), issued_cnt=1.
REQ-038 Back-pressure: push sub 3-5, rsp_ready=0 for 10 cycles -> rsp_result=4'hE and rsp_flags stay stable, alu_* unchanged, rsp_valid held.
REQ-039 Full FIFO: rsp_ready=0, push DEPTH+1 commands -> cmd_ready=0 after DEPTH+1 accepted (DEPTH queued + 1 in HOLD), extra command not accepted; release rsp_ready -> all responses returned in order.
REQ-040 Streaming: 8 random commands with rsp_ready=1 -> responses arrive every 2 cycles, match the golden ALU model, and issued_cnt=8.
REQ-041 Reset mid-stream: assert rst_n=0 while in HOLD with 2 queued -> all outputs at reset values at once; after release, no stale responses appear.
REQ-042 Counter wrap: complete 256 operations -> issued_cnt=0.

Source files
------------

// File: rtl/alu4_issuer.sv
// ---------------------------------------------------------------------------
// alu4_issuer
//
// Queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational 4-bit ALU. It then captures the ALU result and flags
// into a response register, which is held until the consumer accepts it.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_cmd_valid         command offered
//   o_cmd_ready         FIFO can accept (high iff not full)
//   i_cmd_op/a/b        opcode (3b) and operands (4b each) of the command
//   o_alu_a/b/op        registered operands/opcode presented to the ALU
//   i_alu_result        ALU result, combinational from o_alu_*
//   i_alu_carry/overflow/zero   ALU flags
//   o_rsp_valid         response held
//   i_rsp_ready         consumer accepts the response
//   o_rsp_result        captured result
//   o_rsp_flags         captured {carry, overflow, zero}
//   o_rsp_op            opcode that produced the response
//   o_issued_cnt        completed-operation count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module alu4_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [2:0] i_cmd_op,
    input  logic [3:0] i_cmd_a,
    input  logic [3:0] i_cmd_b,
    output logic [3:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic [2:0] o_alu_op,
    input  logic [3:0] i_alu_result,
    input  logic       i_alu_carry,
    input  logic       i_alu_overflow,
    input  logic       i_alu_zero,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [3:0] o_rsp_result,
    output logic [2:0] o_rsp_flags,
    output logic [2:0] o_rsp_op,
    output logic [7:0] o_issued_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    // Command storage: {op, a, b}
    logic [10:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic [1:0]  r_state;
    logic        r_run;
    logic [3:0]  r_alu_a;
    logic [3:0]  r_alu_b;
    logic [2:0]  r_alu_op;
    logic        r_rsp_valid;
    logic [3:0]  r_rsp_result;
    logic [2:0]  r_rsp_flags;
    logic [2:0]  r_rsp_op;
    logic [7:0]  r_issued_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_state_next;
    logic [10:0] w_head;

    // Extra pointer MSB distinguishes full (wrapped) from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign o_cmd_ready = !w_full;

    // r_run is low only until the first edge after reset release, so an edge
    // that coincides with the deassertion can never push or pop. Capture
    // needs a prior pop, so it is covered by the same gate.
    assign w_push = i_cmd_valid && !w_full && r_run;

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_pop        = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_run && !w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // rsp_valid is always set in HOLD, so ready alone completes it.
                if (i_rsp_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Storage array carries no reset; only the pointers define its contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_cmd_op, i_cmd_a, i_cmd_b};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_op     <= '0;
            r_issued_cnt <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            // ALU inputs move only when a command leaves the FIFO.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_alu_op <= w_head[10:8];
                r_alu_a  <= w_head[7:4];
                r_alu_b  <= w_head[3:0];
            end

            if (r_state == ST_ISSUE) begin
                r_rsp_result <= i_alu_result;
                r_rsp_flags  <= {i_alu_carry, i_alu_overflow, i_alu_zero};
                r_rsp_op     <= r_alu_op;
                r_rsp_valid  <= 1'b1;
                r_issued_cnt <= r_issued_cnt + 8'd1;
            end else if ((r_state == ST_HOLD) && i_rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_op     = r_alu_op;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flags  = r_rsp_flags;
    assign o_rsp_op     = r_rsp_op;
    assign o_issued_cnt = r_issued_cnt;

endmodule

// File: tb/tb_alu4_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu4_issuer
//
// Directed bench for alu4_issuer with a behavioural 4-bit ALU attached.
// ALU opcodes: 000 add, 001 sub (carry = borrow), 010 and, 011 or, 100 xor,
// 101 not a, 110 unsigned a<b, 111 a==b. Flags are {carry, overflow, zero}.
// ---------------------------------------------------------------------------
module tb_alu4_issuer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [2:0] rsp_op;
    logic [7:0] issued_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu4_issuer #(.DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_a        (cmd_a),
        .i_cmd_b        (cmd_b),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .i_alu_result   (alu_result),
        .i_alu_carry    (alu_carry),
        .i_alu_overflow (alu_overflow),
        .i_alu_zero     (alu_zero),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_result   (rsp_result),
        .o_rsp_flags    (rsp_flags),
        .o_rsp_op       (rsp_op),
        .o_issued_cnt   (issued_cnt)
    );

    // Behavioural ALU: returns {result, carry, overflow, zero}
    function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = (a < b) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {r, c, v, (r == 4'd0)};
    endfunction

    always_comb begin
        {alu_result, alu_carry, alu_overflow, alu_zero} = alu_fn(alu_op, alu_a, alu_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_handshake got ready,valid=%b required=10", {cmd_ready, rsp_valid});
        end
        checks++;
        if ({rsp_result, rsp_flags, rsp_op} !== 10'd0) begin
            failures++;
            $display("FAIL reset_rsp got %h required 0", {rsp_result, rsp_flags, rsp_op});
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== 11'd0) begin
            failures++;
            $display("FAIL reset_alu got %h required 0", {alu_op, alu_a, alu_b});
        end
        checks++;
        if (issued_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d required 0", issued_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        $display("reset released");
    endtask

    task automatic test_single_add();
        cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd1; cmd_valid = 1'b1;
        tick();                     // push edge
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_early_valid_1 got %b required 0", rsp_valid);
        end
        tick();                     // pop edge
        checks++;
        if ({rsp_valid, alu_op, alu_a, alu_b} !== {1'b0, 3'd0, 4'd7, 4'd1}) begin
            failures++;
            $display("FAIL add_pop got valid,op,a,b=%h required %h",
                     {rsp_valid, alu_op, alu_a, alu_b}, {1'b0, 3'd0, 4'd7, 4'd1});
        end
        tick();                     // capture edge
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_latency got rsp_valid=%b required 1", rsp_valid);
        end
        checks++;
        if ({rsp_result, rsp_flags, rsp_op} !== {4'd8, 3'b010, 3'd0}) begin
            failures++;
            $display("FAIL add_result got result=%h flags=%b op=%0d required 8 010 0",
                     rsp_result, rsp_flags, rsp_op);
        end
        checks++;
        if (issued_cnt !== 8'd1) begin
            failures++;
            $display("FAIL add_cnt got %0d required 1", issued_cnt);
        end
        $display("add 7+1 -> result=%h flags=%b", rsp_result, rsp_flags);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_release got rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        cmd_op = 3'd1; cmd_a = 4'd3; cmd_b = 4'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout got rsp_valid=%b required 1", rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_result, rsp_flags, rsp_op, alu_op, alu_a, alu_b} !==
                {1'b1, 4'hE, 3'b100, 3'd1, 3'd1, 4'd3, 4'd5}) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got v=%b r=%h f=%b op=%0d alu=%0d,%h,%h required 1 e 100 1 1,3,5",
                         i, rsp_valid, rsp_result, rsp_flags, rsp_op, alu_op, alu_a, alu_b);
            end
            tick();
        end
        $display("sub 3-5 held -> result=%h flags=%b", rsp_result, rsp_flags);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, issued_cnt} !== {1'b0, 8'd2}) begin
            failures++;
            $display("FAIL bp_release got valid=%b cnt=%0d required 0 2", rsp_valid, issued_cnt);
        end
    endtask

    task automatic test_full_fifo();
        logic [2:0] c_op  [6];
        logic [3:0] c_a   [6];
        logic [3:0] c_b   [6];
        logic [3:0] e_res [5];
        logic [2:0] e_flg [5];
        int idx;
        c_op = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
        c_a  = '{4'h2, 4'hF, 4'h8, 4'h5, 4'h6, 4'h1};
        c_b  = '{4'h3, 4'h3, 4'h1, 4'h5, 4'h6, 4'h1};
        e_res = '{4'h5, 4'h3, 4'h9, 4'h0, 4'h1};
        e_flg = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        rsp_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_accept_%0d got cmd_ready=%b required 1", k, cmd_ready);
            end
            cmd_op = c_op[k]; cmd_a = c_a[k]; cmd_b = c_b[k]; cmd_valid = 1'b1;
            tick();
        end
        // Offer one more command; it must be refused, including on the edge
        // where the held response is released and the FIFO pops.
        cmd_op = c_op[5]; cmd_a = c_a[5]; cmd_b = c_b[5];
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_refuse_%0d got cmd_ready=%b required 0", i, cmd_ready);
            end
            tick();
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_refuse_pop got cmd_ready=%b required 0", cmd_ready);
        end
        rsp_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (rsp_valid) begin
                if (idx < 5) begin
                    $display("full rsp %0d op=%0d result=%h flags=%b", idx, rsp_op, rsp_result, rsp_flags);
                    checks++;
                    if ({rsp_op, rsp_result, rsp_flags} !== {c_op[idx], e_res[idx], e_flg[idx]}) begin
                        failures++;
                        $display("FAIL full_order_%0d got op=%0d r=%h f=%b required op=%0d r=%h f=%b",
                                 idx, rsp_op, rsp_result, rsp_flags, c_op[idx], e_res[idx], e_flg[idx]);
                    end
                end
                idx++;
            end
            tick();
            if (cyc == 0) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        checks++;
        if (idx != 5) begin
            failures++;
            $display("FAIL full_count got %0d responses required 5", idx);
        end
        checks++;
        if (issued_cnt !== 8'd7) begin
            failures++;
            $display("FAIL full_cnt got %0d required 7", issued_cnt);
        end
    endtask

    task automatic test_stream();
        logic [2:0] s_op  [8];
        logic [3:0] s_a   [8];
        logic [3:0] s_b   [8];
        logic [3:0] e_res [8];
        logic [2:0] e_flg [8];
        int n;
        int last;
        s_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        s_a   = '{4'h9, 4'h4, 4'hA, 4'hA, 4'hC, 4'h3, 4'h2, 4'h4};
        s_b   = '{4'h9, 4'h4, 4'h5, 4'h5, 4'hA, 4'h0, 4'h7, 4'h5};
        e_res = '{4'h2, 4'h0, 4'h0, 4'hF, 4'h6, 4'hC, 4'h1, 4'h0};
        e_flg = '{3'b110, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        do_reset();
        rsp_ready = 1'b1;
        n = 0;
        last = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic acc;
                    int w;
                    cmd_op = s_op[k]; cmd_a = s_a[k]; cmd_b = s_b[k]; cmd_valid = 1'b1;
                    acc = 1'b0;
                    w = 0;
                    while (!acc && w < 20) begin
                        acc = cmd_ready;
                        tick();
                        w++;
                    end
                    if (!acc) begin
                        checks++;
                        failures++;
                        $display("FAIL stream_push_%0d got no acceptance required accept", k);
                    end
                end
                cmd_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 60; cyc++) begin
                    if (rsp_valid) begin
                        $display("stream rsp %0d op=%0d result=%h flags=%b", n, rsp_op, rsp_result, rsp_flags);
                        if (n < 8) begin
                            checks++;
                            if ({rsp_op, rsp_result, rsp_flags} !== {s_op[n], e_res[n], e_flg[n]}) begin
                                failures++;
                                $display("FAIL stream_rsp_%0d got op=%0d r=%h f=%b required op=%0d r=%h f=%b",
                                         n, rsp_op, rsp_result, rsp_flags, s_op[n], e_res[n], e_flg[n]);
                            end
                        end
                        if (n > 0) begin
                            checks++;
                            if (cyc - last != 2) begin
                                failures++;
                                $display("FAIL stream_gap_%0d got %0d cycles required 2", n, cyc - last);
                            end
                        end
                        last = cyc;
                        n++;
                    end
                    tick();
                end
            end
        join
        rsp_ready = 1'b0;
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL stream_count got %0d responses required 8", n);
        end
        checks++;
        if (issued_cnt !== 8'd8) begin
            failures++;
            $display("FAIL stream_cnt got %0d required 8", issued_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cmd_valid = 1'b1;
        cmd_op = 3'd0; cmd_a = 4'd7; cmd_b = 4'd1;
        tick();
        cmd_op = 3'd3; cmd_a = 4'hA; cmd_b = 4'h5;
        tick();
        cmd_op = 3'd4; cmd_a = 4'hC; cmd_b = 4'hA;
        tick();
        cmd_valid = 1'b0;
        tick();                     // FSM in HOLD, two commands queued
        checks++;
        if ({rsp_valid, rsp_result, issued_cnt} !== {1'b1, 4'd8, 8'd1}) begin
            failures++;
            $display("FAIL mid_pre got valid=%b r=%h cnt=%0d required 1 8 1", rsp_valid, rsp_result, issued_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_op} !== {1'b1, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL mid_rst_rsp got ready=%b valid=%b r=%h f=%b op=%0d required 1 0 0 0 0",
                     cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_op);
        end
        checks++;
        if ({alu_op, alu_a, alu_b, issued_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL mid_rst_alu got alu=%0d,%h,%h cnt=%0d required 0", alu_op, alu_a, alu_b, issued_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready} !== 2'b01) begin
                failures++;
                $display("FAIL mid_stale cycle %0d got valid,ready=%b required 01", i, {rsp_valid, cmd_ready});
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (issued_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_cnt got %0d required 0", issued_cnt);
        end
        $display("reset mid-stream done");
    endtask

    task automatic test_counter_wrap();
        int accepted;
        logic seen255;
        logic acc;
        do_reset();
        rsp_ready = 1'b1;
        cmd_op = 3'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_valid = 1'b1;
        accepted = 0;
        seen255 = 1'b0;
        for (int cyc = 0; cyc < 1200 && accepted < 256; cyc++) begin
            acc = cmd_ready;
            tick();
            if (acc) accepted++;
            if (issued_cnt == 8'd255) seen255 = 1'b1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (issued_cnt == 8'd255) seen255 = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (accepted != 256) begin
            failures++;
            $display("FAIL wrap_accepted got %0d required 256", accepted);
        end
        checks++;
        if (seen255 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_255 got seen=%b required 1", seen255);
        end
        checks++;
        if (issued_cnt !== 8'd0) begin
            failures++;
            $display("FAIL wrap_cnt got %0d required 0", issued_cnt);
        end
        $display("counter wrap: issued_cnt=%0d", issued_cnt);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_full_fifo();
        test_stream();
        test_reset_midstream();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
